// File: rtl/instr_encoder_pkg.sv
// Shared opcode values and instruction field layout; the decoder and the encoder both
// read the word format from here, so the two stay in step.
package instr_encoder_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_WRITE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hC;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 9;
  localparam int MODE_BIT  = 8;
  localparam int RA_MSB    = 7;
  localparam int RA_LSB    = 5;
  localparam int RB_MSB    = 4;
  localparam int RB_LSB    = 2;
  localparam int IMM8_MSB  = 7;
  localparam int IMM5_MSB  = 4;
  // WRITE moves imm[4:2] into the low bits; imm[7:5] reuses the rD slot
  localparam int WR_LO_MSB = 2;

  typedef enum logic [1:0] {
    FMT_WRITE,
    FMT_IMM8,
    FMT_REG,
    FMT_ALU_IMM
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [3:0] op, input logic use_imm);
    if (op == OP_WRITE)                   return FMT_WRITE;
    else if (op == OP_LOAD || op == OP_JMP) return FMT_IMM8;
    else if (use_imm)                     return FMT_ALU_IMM;
    else                                  return FMT_REG;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer. err flags immediates the chosen format
// cannot represent exactly.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  rd,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic        mode,
  input  logic [7:0]  imm,
  input  logic        use_imm,
  output logic [15:0] word,
  output logic        err
);

  fmt_e fmt;
  assign fmt = fmt_of(opcode, use_imm);

  always_comb begin
    word = '0;
    err  = 1'b0;
    word[OP_MSB:OP_LSB] = opcode;
    word[MODE_BIT]      = mode;
    case (fmt)
      FMT_WRITE: begin
        word[RD_MSB:RD_LSB] = imm[7:5];
        word[RA_MSB:RA_LSB] = ra;
        word[WR_LO_MSB:0]   = imm[4:2];
        err                 = |imm[1:0];
      end
      FMT_IMM8: begin
        word[RD_MSB:RD_LSB] = rd;
        word[IMM8_MSB:0]    = imm;
      end
      FMT_REG: begin
        word[RD_MSB:RD_LSB] = rd;
        word[RA_MSB:RA_LSB] = ra;
        word[RB_MSB:RB_LSB] = rb;
      end
      FMT_ALU_IMM: begin
        word[RD_MSB:RD_LSB] = rd;
        word[RA_MSB:RA_LSB] = ra;
        word[IMM5_MSB:0]    = imm[4:0];
        // 5-bit signed immediate: upper bits must be sign copies
        err                 = (imm[7:5] != {3{imm[4]}});
      end
      default: begin
        word = '0;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets, buffers up to two words and streams them
// into instruction memory at a wrapping, loadable address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [3:0]        I_opcode,
  input  logic [2:0]        I_rD,
  input  logic [2:0]        I_rA,
  input  logic [2:0]        I_rB,
  input  logic              I_mode,
  input  logic [7:0]        I_imm,
  input  logic              I_use_imm,
  input  logic              I_addr_load,
  input  logic [ADDR_W-1:0] I_addr_value,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [15:0]       O_mem_data,
  input  logic              I_mem_ready,
  output logic              O_wrap,
  output logic              O_error,
  output logic [3:0]        O_error_opcode,
  output logic [15:0]       O_written
);

  logic [15:0]       word;
  logic              enc_err;
  logic [1:0][15:0]  buf_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              take, push, pop;

  instr_pack u_pack (
    .opcode  (I_opcode),
    .rd      (I_rD),
    .ra      (I_rA),
    .rb      (I_rB),
    .mode    (I_mode),
    .imm     (I_imm),
    .use_imm (I_use_imm),
    .word    (word),
    .err     (enc_err)
  );

  // ready depends only on registered count: no pop-to-ready combinational path
  assign O_ready    = (cnt_q != 2'd2);
  assign take       = I_valid && O_ready;
  assign push       = take && !enc_err;
  assign O_mem_we   = (cnt_q != 2'd0);
  assign pop        = O_mem_we && I_mem_ready;
  assign O_mem_data = O_mem_we ? buf_q[0] : 16'h0000;
  assign O_mem_addr = addr_q;

  // buf_q[0] is always the head
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      buf_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          buf_q[cnt_q[0]] <= word;
          cnt_q           <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        2'b11: begin
          // push implies count was 1 here, so the new word becomes head
          buf_q[0] <= word;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      addr_q <= '0;
      O_wrap <= 1'b0;
    end else begin
      O_wrap <= pop && !I_addr_load && (&addr_q);
      if (I_addr_load)
        addr_q <= I_addr_value;
      else if (pop)
        addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      O_written <= 16'h0000;
    else if (pop && O_written != 16'hFFFF)
      O_written <= O_written + 16'h0001;
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      O_error        <= 1'b0;
      O_error_opcode <= 4'h0;
    end else if (take && enc_err) begin
      O_error <= 1'b1;
      if (!O_error)
        O_error_opcode <= I_opcode;
    end
  end

  a_head_stable: assert property (@(posedge I_clk) disable iff (I_reset)
    (O_mem_we && !I_mem_ready && !I_addr_load) |=>
      (O_mem_we && $stable(O_mem_data) && $stable(O_mem_addr)));

  a_cnt_range: assert property (@(posedge I_clk) disable iff (I_reset)
    cnt_q <= 2'd2);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [3:0] OP_ALU = 4'h2;

  logic        I_clk = 0, I_reset = 1, I_valid = 0;
  logic        O_ready;
  logic [3:0]  I_opcode = 0;
  logic [2:0]  I_rD = 0, I_rA = 0, I_rB = 0;
  logic        I_mode = 0, I_use_imm = 0;
  logic [7:0]  I_imm = 0;
  logic        I_addr_load = 0;
  logic [7:0]  I_addr_value = 0;
  logic        O_mem_we;
  logic [7:0]  O_mem_addr;
  logic [15:0] O_mem_data;
  logic        I_mem_ready = 0;
  logic        O_wrap, O_error;
  logic [3:0]  O_error_opcode;
  logic [15:0] O_written;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(8)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
    .I_opcode(I_opcode), .I_rD(I_rD), .I_rA(I_rA), .I_rB(I_rB), .I_mode(I_mode),
    .I_imm(I_imm), .I_use_imm(I_use_imm), .I_addr_load(I_addr_load),
    .I_addr_value(I_addr_value), .O_mem_we(O_mem_we), .O_mem_addr(O_mem_addr),
    .O_mem_data(O_mem_data), .I_mem_ready(I_mem_ready), .O_wrap(O_wrap),
    .O_error(O_error), .O_error_opcode(O_error_opcode), .O_written(O_written)
  );

  always #5 I_clk = ~I_clk;

  // Reference encoding written straight from the format table
  function automatic logic [15:0] model_enc(input logic [3:0] op, input logic [2:0] rd,
      input logic [2:0] ra, input logic [2:0] rb, input logic mode, input logic [7:0] imm,
      input logic use_imm, output logic bad);
    bad = 1'b0;
    if (op == OP_WRITE) begin
      bad = (imm[1:0] != 2'b00);
      return {op, imm[7:5], mode, ra, 2'b00, imm[4:2]};
    end else if (op == OP_LOAD || op == OP_JMP) begin
      return {op, rd, mode, imm};
    end else if (!use_imm) begin
      return {op, rd, mode, ra, rb, 2'b00};
    end else begin
      bad = (imm[7:5] != {imm[4], imm[4], imm[4]});
      return {op, rd, mode, ra, imm[4:0]};
    end
  endfunction

  // Scoreboard: pending words in a queue, address/error/counters as plain variables
  logic [15:0] exp_q[$];
  logic [7:0]  m_addr = 0;
  logic        m_err = 0, m_wrap = 0;
  logic [3:0]  m_eop = 0;
  logic [15:0] m_written = 0;

  always @(negedge I_clk) begin
    logic        do_write, accept, bad;
    logic [15:0] w;
    if (I_reset) begin
      exp_q.delete();
      m_addr = 0; m_err = 0; m_wrap = 0; m_eop = 0; m_written = 0;
    end else begin
      checks++;
      if (O_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL sb_ready got %b want %b", O_ready, exp_q.size() < 2);
      end
      checks++;
      if (O_mem_we !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL sb_we got %b want %b", O_mem_we, exp_q.size() != 0);
      end
      checks++;
      if (O_wrap !== m_wrap) begin
        errors++; $display("FAIL sb_wrap got %b want %b", O_wrap, m_wrap);
      end
      checks++;
      if (O_error !== m_err || O_error_opcode !== m_eop) begin
        errors++; $display("FAIL sb_error got %b/%h want %b/%h", O_error, O_error_opcode, m_err, m_eop);
      end
      checks++;
      if (O_written !== m_written) begin
        errors++; $display("FAIL sb_written got %0d want %0d", O_written, m_written);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (O_mem_addr !== m_addr || O_mem_data !== exp_q[0]) begin
          errors++; $display("FAIL sb_write got %h@%h want %h@%h", O_mem_data, O_mem_addr, exp_q[0], m_addr);
        end
      end
      accept   = I_valid && (exp_q.size() < 2);
      do_write = (exp_q.size() != 0) && I_mem_ready;
      m_wrap   = do_write && !I_addr_load && (m_addr == 8'hFF);
      if (do_write) begin
        void'(exp_q.pop_front());
        if (m_written != 16'hFFFF) m_written = m_written + 1;
      end
      if (I_addr_load) m_addr = I_addr_value;
      else if (do_write) m_addr = m_addr + 1;
      if (accept) begin
        w = model_enc(I_opcode, I_rD, I_rA, I_rB, I_mode, I_imm, I_use_imm, bad);
        if (bad) begin
          if (!m_err) m_eop = I_opcode;
          m_err = 1;
        end else exp_q.push_back(w);
      end
    end
  end

  task automatic tick();
    @(posedge I_clk); #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
      input logic [2:0] rb, input logic mode, input logic [7:0] imm, input logic use_imm);
    I_opcode = op; I_rD = rd; I_rA = ra; I_rB = rb; I_mode = mode; I_imm = imm; I_use_imm = use_imm;
  endtask

  task automatic test_reset();
    I_reset = 1; tick(); tick();
    checks++;
    if (O_mem_we !== 0 || O_mem_addr !== 0 || O_mem_data !== 0 || O_wrap !== 0 ||
        O_error !== 0 || O_error_opcode !== 0 || O_written !== 0) begin
      errors++; $display("FAIL reset_outputs got we%b a%h d%h w%b e%b eo%h n%0d want all zero",
        O_mem_we, O_mem_addr, O_mem_data, O_wrap, O_error, O_error_opcode, O_written);
    end
    I_reset = 0; tick();
    checks++;
    if (O_ready !== 1) begin errors++; $display("FAIL reset_ready got %b want 1", O_ready); end
  endtask

  task automatic test_load();
    I_mem_ready = 1;
    set_fields(OP_LOAD, 3'd5, 3'd0, 3'd0, 1'b1, 8'hA7, 1'b0);
    I_valid = 1; tick(); I_valid = 0;
    checks++;
    if (O_mem_we !== 1 || O_mem_addr !== 8'h00 || O_mem_data !== {OP_LOAD, 3'b101, 1'b1, 8'hA7}) begin
      errors++; $display("FAIL load_word got we%b %h@%h want 1 %h@00", O_mem_we, O_mem_data, O_mem_addr,
        {OP_LOAD, 3'b101, 1'b1, 8'hA7});
    end
    tick();
    checks++;
    if (O_written !== 16'd1 || O_mem_we !== 0) begin
      errors++; $display("FAIL load_written got %0d we%b want 1 we0", O_written, O_mem_we);
    end
  endtask

  task automatic test_write_err();
    logic [15:0] n;
    set_fields(OP_WRITE, 3'd7, 3'd3, 3'd0, 1'b0, 8'hB4, 1'b0);
    I_valid = 1; tick(); I_valid = 0;
    checks++;
    if (O_mem_data !== {OP_WRITE, 3'b101, 1'b0, 3'b011, 2'b00, 3'b101}) begin
      errors++; $display("FAIL write_word got %h want %h", O_mem_data, {OP_WRITE, 3'b101, 1'b0, 3'b011, 2'b00, 3'b101});
    end
    tick();
    n = O_written;
    I_imm = 8'hB5; I_valid = 1; tick(); I_valid = 0;
    checks++;
    if (O_error !== 1 || O_error_opcode !== OP_WRITE || O_mem_we !== 0) begin
      errors++; $display("FAIL write_error got e%b op%h we%b want e1 op%h we0", O_error, O_error_opcode, O_mem_we, OP_WRITE);
    end
    tick();
    checks++;
    if (O_written !== n) begin errors++; $display("FAIL write_error_nowrite got %0d want %0d", O_written, n); end
  endtask

  task automatic test_alu_imm();
    set_fields(OP_ALU, 3'd1, 3'd2, 3'd6, 1'b1, 8'hF0, 1'b1);
    I_valid = 1; tick(); I_valid = 0;
    checks++;
    if (O_mem_we !== 1 || O_mem_data !== {OP_ALU, 3'd1, 1'b1, 3'd2, 5'b10000}) begin
      errors++; $display("FAIL alu_imm got we%b %h want 1 %h", O_mem_we, O_mem_data, {OP_ALU, 3'd1, 1'b1, 3'd2, 5'b10000});
    end
    tick();
    I_imm = 8'h30; I_valid = 1; tick(); I_valid = 0;
    checks++;
    if (O_error !== 1 || O_error_opcode !== OP_WRITE || O_mem_we !== 0) begin
      errors++; $display("FAIL alu_imm_error got e%b op%h we%b want e1 op%h we0", O_error, O_error_opcode, O_mem_we, OP_WRITE);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [7:0]  a0;
    logic [15:0] dA, dB;
    logic bad;
    I_mem_ready = 0;
    set_fields(OP_ALU, 3'd3, 3'd4, 3'd5, 1'b0, 8'h00, 1'b0);
    dA = model_enc(OP_ALU, 3'd3, 3'd4, 3'd5, 1'b0, 8'h00, 1'b0, bad);
    I_valid = 1; tick();
    set_fields(OP_JMP, 3'd6, 3'd0, 3'd0, 1'b1, 8'h5C, 1'b0);
    dB = model_enc(OP_JMP, 3'd6, 3'd0, 3'd0, 1'b1, 8'h5C, 1'b0, bad);
    tick();
    a0 = O_mem_addr;
    set_fields(OP_LOAD, 3'd2, 3'd0, 3'd0, 1'b0, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (O_ready !== 0 || O_mem_addr !== a0 || O_mem_data !== dA) begin
        errors++; $display("FAIL stall_hold got r%b %h@%h want r0 %h@%h", O_ready, O_mem_data, O_mem_addr, dA, a0);
      end
    end
    I_valid = 0; I_mem_ready = 1; tick();
    checks++;
    if (O_mem_addr !== a0 + 8'd1 || O_mem_data !== dB) begin
      errors++; $display("FAIL stall_release got %h@%h want %h@%h", O_mem_data, O_mem_addr, dB, a0 + 8'd1);
    end
    tick();
    checks++;
    if (O_mem_we !== 0) begin errors++; $display("FAIL stall_drain got we%b want 0", O_mem_we); end
  endtask

  task automatic test_wrap();
    logic [7:0] addrs[$];
    int wraps = 0;
    I_mem_ready = 1;
    I_addr_load = 1; I_addr_value = 8'hFF; tick(); I_addr_load = 0;
    checks++;
    if (O_mem_addr !== 8'hFF || O_wrap !== 0) begin
      errors++; $display("FAIL wrap_load got %h w%b want ff w0", O_mem_addr, O_wrap);
    end
    set_fields(OP_LOAD, 3'd1, 3'd0, 3'd0, 1'b0, 8'h01, 1'b0);
    I_valid = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) I_valid = 0;
      else if (i == 0) I_imm = 8'h02;
      if (O_mem_we) addrs.push_back(O_mem_addr);
      if (O_wrap) wraps++;
    end
    checks++;
    if (addrs.size() != 2 || addrs[0] !== 8'hFF || addrs[1] !== 8'h00) begin
      errors++; $display("FAIL wrap_addrs got n%0d want ff,00", addrs.size());
    end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL wrap_pulse got %0d want 1", wraps); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      I_valid      = ($urandom_range(0, 3) != 0);
      I_mem_ready  = ($urandom_range(0, 3) != 0);
      I_addr_load  = ($urandom_range(0, 39) == 0);
      I_addr_value = 8'($urandom);
      set_fields(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) I_imm[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) I_imm[7:5] = {3{I_imm[4]}};
      tick();
    end
    I_valid = 0; I_addr_load = 0; I_mem_ready = 1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midstall();
    I_mem_ready = 0;
    set_fields(OP_LOAD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h3C, 1'b0);
    I_valid = 1; tick(); tick(); I_valid = 0;
    #1 I_reset = 1; #1;
    checks++;
    if (O_mem_we !== 0 || O_mem_addr !== 0 || O_mem_data !== 0 || O_wrap !== 0 ||
        O_error !== 0 || O_error_opcode !== 0 || O_written !== 0) begin
      errors++; $display("FAIL midstall_reset got we%b a%h d%h e%b n%0d want zero",
        O_mem_we, O_mem_addr, O_mem_data, O_error, O_written);
    end
    tick(); I_reset = 0; I_mem_ready = 1; tick(); tick();
    checks++;
    if (O_ready !== 1 || O_mem_we !== 0 || O_written !== 0) begin
      errors++; $display("FAIL midstall_flush got r%b we%b n%0d want r1 we0 n0", O_ready, O_mem_we, O_written);
    end
    set_fields(4'h3, 3'd0, 3'd0, 3'd0, 1'b0, 8'h50, 1'b1);
    I_valid = 1; tick(); I_valid = 0; tick();
    checks++;
    if (O_error !== 1 || O_error_opcode !== 4'h3) begin
      errors++; $display("FAIL post_reset_error got e%b op%h want e1 op3", O_error, O_error_opcode);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_write_err();
    test_alu_imm();
    test_stall();
    test_wrap();
    test_random();
    test_reset_midstall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
